core_interrupt_gateway: RTL and testbench

- Parametrised external-interrupt controller in front of the core's interrupt interface; replaces the single hard-wired ext_int/ext_int_clear pair with NUM_SRC prioritised sources.
- Per-source synchroniser, edge/level gateway, enable mask and priority.
- Configured and claimed through a generic-bus slave port.
- Drives ext_int and ext_int_clear into core_interrupt_if.

---
 rtl/core_interrupt_gateway.sv | 179 +++++++++++++++++
 tb/tb_core_interrupt_gateway.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_interrupt_gateway.sv
// Prioritised external-interrupt gateway: per-source sync, edge/level gateway, claim/complete over a one-wait-state bus.
// Define CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN to queue up to 15 extra edges per edge-mode source.
module core_interrupt_gateway #(
  parameter int NUM_SRC     = 8,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               ren,
  input  logic               wen,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         byte_en,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic               ext_int,
  output logic               ext_int_clear
);
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  state_t r_state, w_state_nxt;

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_s_prev, r_pend, r_en, r_mode, r_isr;
  logic [PRIO_W-1:0]  r_thr;
  logic [PRIO_W-1:0]  r_prio [NUM_SRC];
  logic               r_ext, r_ext_clr;

  logic [NUM_SRC-1:0] w_s, w_rise, w_elig, w_claim_vec, w_cmp_vec, w_pend_nxt;
  logic [5:0]         w_word;
  logic               w_wr, w_rd, w_claim, w_mode_wr;
  logic [4:0]         w_win_id;
  logic [PRIO_W-1:0]  w_best;
  logic               w_unused;

  assign w_unused  = ^{byte_en, addr[31:8], addr[1:0], wdata};
  assign w_word    = addr[7:2];
  assign w_wr      = (r_state == S_ACCESS) & wen;
  assign w_rd      = (r_state == S_ACCESS) & ren & ~wen;
  assign w_claim   = w_rd & (w_word == 6'd4) & (w_win_id != 5'd0);
  assign w_mode_wr = w_wr & (w_word == 6'd2);
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_prev;
  assign ext_int       = r_ext;
  assign ext_int_clear = r_ext_clr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ren || wen) begin
          w_state_nxt = S_ACCESS;
          busy        = 1'b1;
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_vec[i] = w_claim && (w_win_id == 5'(i + 1));
      w_cmp_vec[i]   = w_wr && (w_word == 6'd4) && (wdata[4:0] == 5'(i + 1));
      w_elig[i]      = r_pend[i] & r_en[i] & ~r_isr[i] & (r_prio[i] > r_thr);
    end
  end

  // Strict '>' while scanning upwards keeps the lowest ID on a priority tie.
  always_comb begin
    w_win_id = 5'd0;
    w_best   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i] && (r_prio[i] > w_best)) begin
        w_best   = r_prio[i];
        w_win_id = 5'(i + 1);
      end
    end
  end

`ifdef CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN
  logic [3:0] r_cnt     [NUM_SRC];
  logic [3:0] w_cnt_nxt [NUM_SRC];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pend_nxt[i] = r_pend[i];
`ifdef CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN
      w_cnt_nxt[i] = r_cnt[i];
`endif
      if (!r_mode[i]) begin
        w_pend_nxt[i] = w_s[i] & ~r_isr[i];
      end else begin
        if (w_claim_vec[i]) w_pend_nxt[i] = 1'b0;
        if (w_rise[i])      w_pend_nxt[i] = 1'b1;
`ifdef CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN
        // A queued edge re-arms pending as soon as the current one is claimed.
        if (w_claim_vec[i] && !w_rise[i] && (r_cnt[i] != 4'd0)) begin
          w_pend_nxt[i] = 1'b1;
          w_cnt_nxt[i]  = r_cnt[i] - 4'd1;
        end else if (w_rise[i] && r_pend[i] && !w_claim_vec[i] && (r_cnt[i] != 4'hF)) begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
`endif
      end
`ifdef CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN
      if (!r_mode[i] || w_mode_wr) w_cnt_nxt[i] = 4'd0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
      r_s_prev  <= '0;
      r_pend    <= '0;
      r_en      <= '0;
      r_mode    <= '0;
      r_isr     <= '0;
      r_thr     <= '0;
      r_ext     <= 1'b0;
      r_ext_clr <= 1'b0;
    end else begin
      r_sync[0] <= src_irq;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_s_prev  <= w_s;
      r_pend    <= w_pend_nxt;
      r_isr     <= (r_isr | w_claim_vec) & ~w_cmp_vec;
      r_ext     <= |w_elig;
      r_ext_clr <= r_ext & ~(|w_elig);
      if (w_wr) begin
        case (w_word)
          6'd1:    r_en   <= wdata[NUM_SRC-1:0];
          6'd2:    r_mode <= wdata[NUM_SRC-1:0];
          6'd3:    r_thr  <= wdata[PRIO_W-1:0];
          default: ;
        endcase
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_wr && (w_word == 6'(8 + i))) r_prio[i] <= wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_word)
        6'd0: rdata[NUM_SRC-1:0] = r_pend;
        6'd1: rdata[NUM_SRC-1:0] = r_en;
        6'd2: rdata[NUM_SRC-1:0] = r_mode;
        6'd3: rdata[PRIO_W-1:0]  = r_thr;
        6'd4: rdata[4:0]         = w_win_id;
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (w_word == 6'(8 + i)) rdata[PRIO_W-1:0] = r_prio[i];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_interrupt_gateway.sv
// Randomised + directed bench for core_interrupt_gateway against an event-level reference model.
module tb_core_interrupt_gateway;
  localparam int NUM_SRC     = 8;
  localparam int PRIO_W      = 3;
  localparam int SYNC_STAGES = 2;
`ifdef CORE_INTERRUPT_GATEWAY_EDGE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [NUM_SRC-1:0] src_irq = '0;
  logic               ren = 1'b0, wen = 1'b0;
  logic [31:0]        addr = '0, wdata = '0;
  logic [3:0]         byte_en = 4'hF;
  logic [31:0]        rdata;
  logic               busy, ext_int, ext_int_clear;

  core_interrupt_gateway #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RST(RST), .src_irq(src_irq), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .busy(busy),
    .ext_int(ext_int), .ext_int_clear(ext_int_clear)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every falling ext_int must coincide with exactly one clear pulse.
  int n_fall = 0, n_clr = 0, n_clr_bad = 0;
  logic prev_ext = 1'b0;
  always @(negedge CLK) begin
    if (RST) prev_ext = 1'b0;
    else begin
      if (prev_ext && !ext_int) n_fall++;
      if (ext_int_clear) n_clr++;
      if (ext_int_clear && ext_int) n_clr_bad++;
      prev_ext = ext_int;
    end
  end

  // Reference model: state changes only at bench events.
  logic [NUM_SRC-1:0] m_pend, m_isr, m_en, m_mode, m_lvl;
  int m_prio [NUM_SRC];
  int m_cnt  [NUM_SRC];
  int m_thr;

  task automatic m_clear();
    m_pend = '0; m_isr = '0; m_en = '0; m_mode = '0; m_lvl = '0; m_thr = 0;
    for (int i = 0; i < NUM_SRC; i++) begin m_prio[i] = 0; m_cnt[i] = 0; end
  endtask

  function automatic logic m_peff(input int i);
    return m_mode[i] ? m_pend[i] : (m_lvl[i] & ~m_isr[i]);
  endfunction

  function automatic int m_winner();
    int best = 0, id = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (m_peff(i) && m_en[i] && !m_isr[i] && m_prio[i] > m_thr && m_prio[i] > best) begin
        best = m_prio[i]; id = i + 1;
      end
    return id;
  endfunction

  function automatic logic [31:0] m_pending_word();
    logic [31:0] w = '0;
    for (int i = 0; i < NUM_SRC; i++) w[i] = m_peff(i);
    return w;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus(input bit wr, input logic [7:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n = 0;
    @(negedge CLK);
    ren = !wr; wen = wr; addr = {24'h5A5A5A, a}; wdata = d;
    #1 chk("busy_req", 32'(busy), 32'd1);
    @(negedge CLK);
    while (busy && n < 8) begin @(negedge CLK); n++; end
    chk("wait_state", n, 0);
    rd = rdata;
    @(posedge CLK); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int id;
    bus(1'b1, a, d, rd);
    case (a)
      8'h04: m_en = d[NUM_SRC-1:0];
      8'h08: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (d[i] && !m_mode[i]) m_pend[i] = m_lvl[i] & ~m_isr[i];
          m_cnt[i] = 0;
        end
        m_mode = d[NUM_SRC-1:0];
      end
      8'h0C: m_thr = int'(d[PRIO_W-1:0]);
      8'h10: begin
        id = int'(d[4:0]);
        if (id >= 1 && id <= NUM_SRC) m_isr[id-1] = 1'b0;
      end
      default: if (a >= 8'h20 && a < 8'(32 + 4 * NUM_SRC)) m_prio[(int'(a) - 32) / 4] = int'(d[PRIO_W-1:0]);
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic claim(input string tag, output int id);
    logic [31:0] rd;
    int exp;
    exp = m_winner();
    bus(1'b0, 8'h10, 32'd0, rd);
    chk(tag, rd, exp);
    id = int'(rd);
    if (exp != 0) begin
      m_isr[exp-1] = 1'b1;
      if (m_mode[exp-1]) begin
        if (m_cnt[exp-1] > 0) begin m_cnt[exp-1]--; m_pend[exp-1] = 1'b1; end
        else m_pend[exp-1] = 1'b0;
      end
    end
  endtask

  task automatic set_src(input int i, input logic v);
    if (v && !m_lvl[i] && m_mode[i]) begin
      if (!m_pend[i]) m_pend[i] = 1'b1;
      else if (CNT_EN && m_cnt[i] < 15) m_cnt[i]++;
    end
    m_lvl[i] = v;
    @(negedge CLK);
    src_irq[i] = v;
    cycles(SYNC_STAGES + 3);
  endtask

  task automatic pulse(input int i);
    set_src(i, 1'b1);
    set_src(i, 1'b0);
  endtask

  task automatic chk_ext(input string tag);
    cycles(3);
    chk(tag, 32'(ext_int), 32'(m_winner() != 0));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; src_irq = '0; ren = 1'b0; wen = 1'b0;
    cycles(2);
    RST = 1'b0;
    m_clear();
  endtask

  initial begin
    int id, k, c0;
    m_clear();
    // Reset state, then a reset landing in the middle of a write access
    cycles(2);
    RST = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ext", 32'(ext_int), 32'd0);
    chk("rst_clr", 32'(ext_int_clear), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge CLK);
    wen = 1'b1; addr = 32'h04; wdata = 32'hFF;
    @(posedge CLK); #2;
    RST = 1'b1; wen = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_rdata", rdata, 32'd0);
    chk("t1_ext", 32'(ext_int), 32'd0);
    cycles(2);
    RST = 1'b0;
    rd_chk("t1_enable", 8'h04, 32'd0);
    rd_chk("t1_pending", 8'h00, 32'd0);

    // Priority and tie-break
    reg_wr(8'h04, 32'hFF);
    reg_wr(8'h28, 32'd5);
    reg_wr(8'h34, 32'd5);
    reg_wr(8'h20, 32'd3);
    reg_wr(8'h0C, 32'd2);
    @(negedge CLK);
    src_irq[0] = 1'b1; src_irq[2] = 1'b1; src_irq[5] = 1'b1;
    m_lvl[0] = 1'b1; m_lvl[2] = 1'b1; m_lvl[5] = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge CLK);
    chk("t2_ext_early", 32'(ext_int), 32'd0);
    @(negedge CLK);
    chk("t2_ext_on", 32'(ext_int), 32'd1);
    claim("t2_claim_a", id); chk("t2_id3", id, 3);
    claim("t2_claim_b", id); chk("t2_id6", id, 6);
    claim("t2_claim_c", id); chk("t2_id1", id, 1);
    claim("t2_claim_d", id); chk("t2_id0", id, 0);
    chk_ext("t2_ext_off");
    set_src(0, 1'b0); set_src(2, 1'b0); set_src(5, 1'b0);
    reg_wr(8'h10, 32'd1); reg_wr(8'h10, 32'd3); reg_wr(8'h10, 32'd6);

    // Threshold gating
    reg_wr(8'h20, 32'd2);
    set_src(0, 1'b1);
    cycles(3);
    chk("t3_ext_blocked", 32'(ext_int), 32'd0);
    reg_wr(8'h0C, 32'd1);
    k = 0;
    while (!ext_int && k < 2) begin @(negedge CLK); k++; end
    chk("t3_ext_thr", 32'(ext_int), 32'd1);

    // Level gating while in service
    claim("t5_claim", id); chk("t5_id1", id, 1);
    cycles(6);
    chk("t5_ext_insvc", 32'(ext_int), 32'd0);
    reg_wr(8'h10, 32'd7);
    chk_ext("t5_ext_cmp7");
    rd_chk("t5_pending", 8'h00, m_pending_word());
    reg_wr(8'h10, 32'd1);
    chk_ext("t5_ext_back");
    chk("t5_ext_one", 32'(ext_int), 32'd1);
    set_src(0, 1'b0);
    chk_ext("t5_ext_drop");

    // Edge claim/complete and the clear pulse
    reg_wr(8'h08, 32'h1);
    pulse(0);
    rd_chk("t4_pend_set", 8'h00, 32'h1);
    chk_ext("t4_ext_on");
    c0 = n_clr;
    claim("t4_claim", id); chk("t4_id1", id, 1);
    cycles(4);
    chk("t4_ext_off", 32'(ext_int), 32'd0);
    chk("t4_clr_pulses", n_clr - c0, 1);
    rd_chk("t4_pend_clr", 8'h00, 32'h0);
    reg_wr(8'h10, 32'd1);
    pulse(0);
    rd_chk("t4_pend_again", 8'h00, 32'h1);
    claim("t4_claim2", id);
    reg_wr(8'h10, 32'd1);

    // Edges arriving while already pending
    reg_wr(8'h08, 32'h3);
    reg_wr(8'h24, 32'd4);
    pulse(1); pulse(1); pulse(1);
    claim("t6_claim_a", id); chk("t6_id_a", id, 2);
    reg_wr(8'h10, 32'd2);
    claim("t6_claim_b", id); chk("t6_id_b", id, CNT_EN ? 2 : 0);
    reg_wr(8'h10, 32'd2);
    claim("t6_claim_c", id); chk("t6_id_c", id, CNT_EN ? 2 : 0);
    reg_wr(8'h10, 32'd2);

    // Randomised traffic
    do_reset();
    reg_wr(8'h04, $urandom_range(0, 255));
    reg_wr(8'h08, $urandom_range(0, 255));
    reg_wr(8'h0C, $urandom_range(0, 3));
    for (int i = 0; i < NUM_SRC; i++) reg_wr(8'(32 + 4 * i), $urandom_range(0, 7));
    for (int it = 0; it < 90; it++) begin
      int op, s;
      op = $urandom_range(0, 5);
      s  = $urandom_range(0, NUM_SRC - 1);
      case (op)
        0: if (!m_lvl[s]) pulse(s);
        1: set_src(s, !m_lvl[s]);
        2: claim("rnd_claim", id);
        3: reg_wr(8'h10, $urandom_range(0, NUM_SRC + 2));
        4: rd_chk("rnd_pending", 8'h00, m_pending_word());
        default: reg_wr(8'h08, $urandom_range(0, 255));
      endcase
      chk_ext("rnd_ext");
    end

    chk("clr_vs_fall", n_clr, n_fall);
    chk("clr_while_int", n_clr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
